// File: rtl/serial_rx_capture_pkg.sv
// Shared definitions for the serial capture block: FSM encodings, default
// bit period and FIFO entry width ({frame_err, data[7:0]}).
package serial_rx_capture_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam int CLK_DIV_DEFAULT = 106;
  localparam int ENTRY_W         = 9;

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic frame_err,
                                                     input logic [7:0] data);
    return {frame_err, data};
  endfunction

endpackage

// File: rtl/serial_rx_capture_if.sv
// Byte output stream of the serial capture block: valid/ready plus the head
// byte and its framing-error flag.
interface serial_rx_capture_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_frame_err;

  modport master (output out_valid, output out_data, output out_frame_err,
                  input  out_ready);
  modport slave  (input  out_valid, input  out_data, input  out_frame_err,
                  output out_ready);
endinterface

// File: rtl/serial_fifo_fwft.sv
// First-word-fall-through FIFO. A push into a full FIFO is accepted only when
// a pop happens in the same cycle; otherwise it is dropped and flagged.
module serial_fifo_fwft #(
  parameter int DEPTH   = 16,
  parameter int WIDTH   = 9,
  parameter int LEVEL_W = 5
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               wr_en,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               rd_en,
  output logic [WIDTH-1:0]   rd_data,
  output logic               empty,
  output logic               drop,
  output logic [LEVEL_W-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [LEVEL_W-1:0] wr_cnt;
  logic [LEVEL_W-1:0] rd_cnt;
  logic               full;
  logic               do_pop;
  logic               do_push;

  assign level   = wr_cnt - rd_cnt;
  assign empty   = (level == '0);
  assign full    = (level == LEVEL_W'(DEPTH));
  assign do_pop  = rd_en && !empty;
  assign do_push = wr_en && (!full || do_pop);
  assign drop    = wr_en && full && !do_pop;
  assign rd_data = mem[rd_cnt[AW-1:0]];

  // Storage is reset so the head reads back as zero after any reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (do_push) begin
        mem[wr_cnt[AW-1:0]] <= wr_data;
        wr_cnt              <= wr_cnt + LEVEL_W'(1);
      end
      if (do_pop) rd_cnt <= rd_cnt + LEVEL_W'(1);
    end
  end

endmodule

// File: rtl/serial_rx_capture.sv
// 8N1 UART receiver feeding a FWFT byte FIFO, with framing-error tagging and
// a sticky overflow flag.
module serial_rx_capture
  import serial_rx_capture_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_DEFAULT,
  parameter int FIFO_DEPTH = 16,
  parameter int LEVEL_W    = 5
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                rx,
  serial_rx_capture_if.master out_if,
  output logic                overflow,
  input  logic                clear_overflow,
  output logic [LEVEL_W-1:0]  level
);

  localparam int HALF  = CLK_DIV / 2;
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);

  rx_state_t          state;
  logic               sync1;
  logic               rs;
  logic               rs_prev;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         idx;
  logic [7:0]         shreg;
  logic               push;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head;
  logic               empty;
  logic               drop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1   <= 1'b1;
      rs      <= 1'b1;
      rs_prev <= 1'b1;
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
    end else begin
      sync1   <= rx;
      rs      <= sync1;
      rs_prev <= rs;
      case (state)
        IDLE: begin
          if (rs_prev && !rs) begin
            state <= START;
            cnt   <= CNT_HALF;
          end
        end
        START: begin
          if (cnt == '0) begin
            if (rs) begin
              state <= IDLE;
            end else begin
              state <= DATA;
              cnt   <= CNT_BIT;
              idx   <= '0;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == '0) begin
            shreg <= {rs, shreg[7:1]};
            cnt   <= CNT_BIT;
            if (idx == 3'd7) state <= STOP;
            else             idx   <= idx + 3'd1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        STOP: begin
          // A low stop bit parks in BREAK so a held-low line is not re-decoded.
          if (cnt == '0) state <= rs ? IDLE : BREAK;
          else           cnt   <= cnt - CNT_W'(1);
        end
        BREAK: begin
          if (rs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign push      = (state == STOP) && (cnt == '0);
  assign push_data = pack_entry(~rs, shreg);

  serial_fifo_fwft #(
    .DEPTH   (FIFO_DEPTH),
    .WIDTH   (ENTRY_W),
    .LEVEL_W (LEVEL_W)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (push),
    .wr_data (push_data),
    .rd_en   (out_if.out_ready),
    .rd_data (head),
    .empty   (empty),
    .drop    (drop),
    .level   (level)
  );

  assign out_if.out_valid     = ~empty;
  assign out_if.out_data      = head[7:0];
  assign out_if.out_frame_err = head[8];

  // A drop in the same cycle beats clear_overflow.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)             overflow <= 1'b0;
    else if (drop)           overflow <= 1'b1;
    else if (clear_overflow) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_serial_rx_capture.sv
// Directed bench for serial_rx_capture: timing, glitch, framing, overflow,
// full-with-pop and mid-frame reset.
module tb_serial_rx_capture;
  import serial_rx_capture_pkg::*;

  localparam int CD = 106;

  logic       clk = 1'b0;
  logic       resetn;
  logic       rx;
  logic       overflow;
  logic       clear_overflow;
  logic [4:0] level;
  int         checks = 0;
  int         failures = 0;
  int         lat;

  serial_rx_capture_if out_if();

  serial_rx_capture #(.CLK_DIV(CD), .FIFO_DEPTH(16), .LEVEL_W(5)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .rx             (rx),
    .out_if         (out_if),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .level          (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int stop_cycles, input logic stop_val);
    rx = 1'b0;
    tick(CD);
    for (int b = 0; b < 8; b++) begin
      rx = d[b];
      tick(CD);
    end
    rx = stop_val;
    tick(stop_cycles);
    rx = 1'b1;
  endtask

  task automatic pop_one();
    out_if.out_ready = 1'b1;
    tick(1);
    out_if.out_ready = 1'b0;
  endtask

  initial begin
    rx               = 1'b1;
    resetn           = 1'b0;
    clear_overflow   = 1'b0;
    out_if.out_ready = 1'b0;
    tick(3);
    chk("rst_valid", 32'(out_if.out_valid), 0);
    chk("rst_data", 32'(out_if.out_data), 0);
    chk("rst_ferr", 32'(out_if.out_frame_err), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    resetn = 1'b1;
    tick(5);

    // Single byte with latency measurement
    out_if.out_ready = 1'b1;
    lat = 0;
    fork
      send_frame(8'h55, CD, 1'b1);
      begin
        while (lat < 1100 && !out_if.out_valid) begin
          @(posedge clk);
          #1;
          lat++;
        end
        chk("single_latency", 32'(lat), 1010);
        chk("single_data", 32'(out_if.out_data), 32'h55);
        chk("single_ferr", 32'(out_if.out_frame_err), 0);
      end
    join
    tick(5);
    chk("single_drained_level", 32'(level), 0);
    chk("single_drained_valid", 32'(out_if.out_valid), 0);
    out_if.out_ready = 1'b0;

    // Glitch shorter than half a bit
    rx = 1'b0;
    tick(20);
    rx = 1'b1;
    tick(100);
    chk("glitch_level", 32'(level), 0);
    chk("glitch_valid", 32'(out_if.out_valid), 0);
    chk("glitch_state", 32'(dut.state), 32'(IDLE));

    // Framing error with long low stop bit, then a clean byte
    send_frame(8'hA3, 300, 1'b0);
    tick(20);
    chk("ferr_level", 32'(level), 1);
    chk("ferr_data", 32'(out_if.out_data), 32'hA3);
    chk("ferr_flag", 32'(out_if.out_frame_err), 1);
    chk("ferr_state", 32'(dut.state), 32'(IDLE));
    pop_one();
    send_frame(8'h41, CD, 1'b1);
    tick(5);
    chk("after_break_level", 32'(level), 1);
    chk("after_break_data", 32'(out_if.out_data), 32'h41);
    chk("after_break_ferr", 32'(out_if.out_frame_err), 0);
    pop_one();

    // Overflow: 17 bytes into a 16-entry FIFO
    for (int i = 0; i < 17; i++) send_frame(8'(i), CD, 1'b1);
    tick(5);
    chk("ovf_level", 32'(level), 16);
    chk("ovf_flag", 32'(overflow), 1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf_drain_%0d", i), 32'(out_if.out_data), 32'(i));
      pop_one();
    end
    chk("ovf_empty_level", 32'(level), 0);
    chk("ovf_sticky", 32'(overflow), 1);
    clear_overflow = 1'b1;
    tick(1);
    clear_overflow = 1'b0;
    chk("ovf_cleared", 32'(overflow), 0);

    // Full FIFO with a pop in the stop-sample cycle
    for (int i = 0; i < 16; i++) send_frame(8'(8'h20 + i), CD, 1'b1);
    tick(5);
    chk("full_level", 32'(level), 16);
    chk("full_ovf", 32'(overflow), 0);
    fork
      send_frame(8'h30, CD, 1'b1);
      begin
        tick(1009);
        out_if.out_ready = 1'b1;
        tick(1);
        out_if.out_ready = 1'b0;
      end
    join
    tick(5);
    chk("fullpop_level", 32'(level), 16);
    chk("fullpop_ovf", 32'(overflow), 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("fullpop_drain_%0d", i), 32'(out_if.out_data), 32'(8'h21 + i));
      pop_one();
    end

    // Reset during data bit 3 with a byte already queued
    send_frame(8'h5A, CD, 1'b1);
    tick(5);
    chk("pre_reset_level", 32'(level), 1);
    fork
      send_frame(8'h7E, CD, 1'b1);
      begin
        tick(CD * 4 + 50);
        resetn = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_if.out_valid), 0);
        chk("midrst_data", 32'(out_if.out_data), 0);
        chk("midrst_ferr", 32'(out_if.out_frame_err), 0);
        chk("midrst_level", 32'(level), 0);
        chk("midrst_ovf", 32'(overflow), 0);
        chk("midrst_state", 32'(dut.state), 32'(IDLE));
      end
    join
    tick(2);
    resetn = 1'b1;
    tick(3);

    // Back-to-back frames with no idle gap
    send_frame(8'h0D, CD, 1'b1);
    send_frame(8'h0A, CD, 1'b1);
    tick(5);
    chk("b2b_level", 32'(level), 2);
    chk("b2b_first", 32'(out_if.out_data), 32'h0D);
    pop_one();
    chk("b2b_second", 32'(out_if.out_data), 32'h0A);
    chk("b2b_second_ferr", 32'(out_if.out_frame_err), 0);
    pop_one();
    chk("b2b_empty", 32'(out_if.out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
